// File: rtl/flash_arb_pkg.sv
// rtl/flash_arb_pkg.sv - shared state type, requester indices and idle pin values for the flash bus arbiter
package flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_TURN = 2'd3
    } arb_state_e;

    localparam int REQ_SPI  = 0;
    localparam int REQ_QSPI = 1;

    localparam logic       IDLE_SCK  = 1'b0;
    localparam logic       IDLE_CS   = 1'b1;
    localparam logic [3:0] IDLE_DATA = 4'b0000;
    localparam logic [3:0] IDLE_OE   = 4'b0000;

endpackage

// File: rtl/flash_arb_cnt.sv
// rtl/flash_arb_cnt.sv - loadable down-counter that holds at zero and flags it
module flash_arb_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/flash_bus_arbiter.sv
// rtl/flash_bus_arbiter.sv - shares the serial flash between SPI master and QSPI controller; FLASH_ARB_TIMEOUT_EN enables grant revoke
module flash_bus_arbiter
    import flash_arb_pkg::*;
#(
    parameter int TURN_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic [1:0] iREQ,
    output logic [1:0] oGNT,
    input  logic       iSPI_SCK,
    input  logic       iSPI_MOSI,
    input  logic       iSPI_CS,
    input  logic       iQSPI_DCLK,
    input  logic       iQSPI_NCS,
    input  logic [3:0] iQSPI_DATAOUT,
    input  logic [3:0] iQSPI_DATAOE,
    output logic       oFLASH_SCK,
    output logic       oFLASH_CS,
    output logic [3:0] oFLASH_DATA,
    output logic [3:0] oFLASH_OE,
    output logic       oBUSY,
    output logic       oTIMEOUT
);

    arb_state_e state_q, state_d;
    logic       rr_q, rr_d;
    logic [1:0] gnt_q;
    logic       busy_q;
    logic       sck_q, cs_q;
    logic [3:0] data_q, oe_q;
    logic [1:0] req_eff;
    logic       revoke;
    logic       turn_zero, turn_load;

    assign turn_load = iRESET || ((state_d == ST_TURN) && (state_q != ST_TURN));

    flash_arb_cnt #(.WIDTH(8)) u_turn_cnt (
        .clk_i      (iCLK),
        .load_i     (turn_load),
        .load_val_i (8'(TURN_CYCLES - 1)),
        .en_i       (state_q == ST_TURN),
        .zero_o     (turn_zero)
    );

`ifdef FLASH_ARB_TIMEOUT_EN
    logic [1:0] blk_q;
    logic       timeout_q;
    logic       to_zero;
    logic       to_load;

    assign to_load = iRESET || ((state_q == ST_IDLE) && (state_d != ST_IDLE));

    flash_arb_cnt #(.WIDTH(16)) u_to_cnt (
        .clk_i      (iCLK),
        .load_i     (to_load),
        .load_val_i (16'(TIMEOUT_CYCLES - 1)),
        .en_i       ((state_q == ST_OWN0) || (state_q == ST_OWN1)),
        .zero_o     (to_zero)
    );

    // A revoked requester stays masked until it lets go of its request once.
    assign req_eff  = iREQ & ~blk_q;
    assign revoke   = to_zero &&
                      (((state_q == ST_OWN0) && iREQ[REQ_SPI]  && req_eff[REQ_QSPI]) ||
                       ((state_q == ST_OWN1) && iREQ[REQ_QSPI] && req_eff[REQ_SPI]));
    assign oTIMEOUT = timeout_q;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            blk_q     <= 2'b00;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= revoke;
            blk_q     <= blk_q & iREQ;
            if (revoke) begin
                blk_q[state_q == ST_OWN1] <= 1'b1;
            end
        end
    end
`else
    assign req_eff  = iREQ;
    assign revoke   = 1'b0;
    assign oTIMEOUT = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_eff == 2'b11) begin
                    state_d = rr_q ? ST_OWN1 : ST_OWN0;
                    rr_d    = ~rr_q;
                end else if (req_eff[REQ_SPI]) begin
                    state_d = ST_OWN0;
                    rr_d    = 1'b1;
                end else if (req_eff[REQ_QSPI]) begin
                    state_d = ST_OWN1;
                    rr_d    = 1'b0;
                end
            end
            ST_OWN0: if (!iREQ[REQ_SPI] || revoke)  state_d = ST_TURN;
            ST_OWN1: if (!iREQ[REQ_QSPI] || revoke) state_d = ST_TURN;
            ST_TURN: if (turn_zero)                 state_d = ST_IDLE;
            default:                                state_d = ST_TURN;
        endcase
        if (revoke) begin
            rr_d = (state_q == ST_OWN0);
        end
    end

    // Pins follow the next state so grant, CS release and data hand-over land on the same edge.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q <= ST_TURN;
            rr_q    <= 1'b0;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b1;
            sck_q   <= IDLE_SCK;
            cs_q    <= IDLE_CS;
            data_q  <= IDLE_DATA;
            oe_q    <= IDLE_OE;
        end else begin
            state_q         <= state_d;
            rr_q            <= rr_d;
            gnt_q[REQ_SPI]  <= (state_d == ST_OWN0);
            gnt_q[REQ_QSPI] <= (state_d == ST_OWN1);
            busy_q          <= (state_d != ST_IDLE);
            case (state_d)
                ST_OWN0: begin
                    sck_q  <= iSPI_SCK;
                    cs_q   <= iSPI_CS;
                    data_q <= {2'b11, 1'b0, iSPI_MOSI};
                    oe_q   <= 4'b1101;
                end
                ST_OWN1: begin
                    sck_q  <= iQSPI_DCLK & ~iQSPI_NCS;
                    cs_q   <= iQSPI_NCS;
                    data_q <= iQSPI_DATAOUT;
                    oe_q   <= iQSPI_DATAOE & {4{~iQSPI_NCS}};
                end
                default: begin
                    sck_q  <= IDLE_SCK;
                    cs_q   <= IDLE_CS;
                    data_q <= IDLE_DATA;
                    oe_q   <= IDLE_OE;
                end
            endcase
        end
    end

    assign oGNT        = gnt_q;
    assign oBUSY       = busy_q;
    assign oFLASH_SCK  = sck_q;
    assign oFLASH_CS   = cs_q;
    assign oFLASH_DATA = data_q;
    assign oFLASH_OE   = oe_q;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// tb/tb_flash_bus_arbiter.sv - scoreboard bench for flash_bus_arbiter
module tb_flash_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] req;
    logic       spi_sck, spi_mosi, spi_cs;
    logic       qdclk, qncs;
    logic [3:0] qdata, qoe;
    logic [1:0] gnt;
    logic       f_sck, f_cs, busy, tmo;
    logic [3:0] f_data, f_oe;

    flash_bus_arbiter #(.TURN_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .iCLK          (clk),
        .iRESET        (rst),
        .iREQ          (req),
        .oGNT          (gnt),
        .iSPI_SCK      (spi_sck),
        .iSPI_MOSI     (spi_mosi),
        .iSPI_CS       (spi_cs),
        .iQSPI_DCLK    (qdclk),
        .iQSPI_NCS     (qncs),
        .iQSPI_DATAOUT (qdata),
        .iQSPI_DATAOE  (qoe),
        .oFLASH_SCK    (f_sck),
        .oFLASH_CS     (f_cs),
        .oFLASH_DATA   (f_data),
        .oFLASH_OE     (f_oe),
        .oBUSY         (busy),
        .oTIMEOUT      (tmo)
    );

    typedef struct {
        string      tag;
        logic [1:0] gnt;
        logic       busy;
        logic       to;
        logic [9:0] pins;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {sck, cs, data[3:0], oe[3:0]} the flash pins must show for a given grant
    function automatic logic [9:0] pins_for(input logic [1:0] g);
        case (g)
            2'b01:   return {spi_sck, spi_cs, 3'b110, spi_mosi, 4'b1101};
            2'b10:   return {qdclk & ~qncs, qncs, qdata, qoe & {4{~qncs}}};
            default: return {1'b0, 1'b1, 4'b0000, 4'b0000};
        endcase
    endfunction

    task automatic cyc(input string tag, input logic [1:0] g, input logic b, input logic t);
        exp_t e;
        e.tag  = tag;
        e.gnt  = g;
        e.busy = b;
        e.to   = t;
        e.pins = pins_for(g);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({e.tag, ".gnt"},  {14'b0, gnt},  {14'b0, e.gnt});
        chk({e.tag, ".busy"}, {15'b0, busy}, {15'b0, e.busy});
        chk({e.tag, ".to"},   {15'b0, tmo},  {15'b0, e.to});
        chk({e.tag, ".pins"}, {6'b0, f_sck, f_cs, f_data, f_oe}, {6'b0, e.pins});
    endtask

    task automatic turn(input string tag);
        for (int i = 0; i < 4; i++) cyc(tag, 2'b00, 1'b1, 1'b0);
        cyc({tag, "_idle"}, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00;
        spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b1;
        qdclk = 1'b0; qncs = 1'b1; qdata = 4'h0; qoe = 4'h0;

        cyc("rst", 2'b00, 1'b1, 1'b0);
        cyc("rst", 2'b00, 1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc("rst_turn", 2'b00, 1'b1, 1'b0);
        cyc("rst_idle", 2'b00, 1'b0, 1'b0);
        cyc("idle", 2'b00, 1'b0, 1'b0);

        req = 2'b11;
        cyc("both_gnt0", 2'b01, 1'b1, 1'b0);
        cyc("both_hold0", 2'b01, 1'b1, 1'b0);
        req = 2'b10;
        turn("rr_turn");
        cyc("rr_gnt1", 2'b10, 1'b1, 1'b0);
        cyc("rr_hold1", 2'b10, 1'b1, 1'b0);
        req = 2'b00;
        turn("turn1");
        req = 2'b11;
        cyc("rr_back0", 2'b01, 1'b1, 1'b0);
        req = 2'b01;
        cyc("solo0", 2'b01, 1'b1, 1'b0);
        req = 2'b10;
        turn("swap_turn");
        cyc("swap_gnt1", 2'b10, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            qncs  = (i >= 2 && i < 13) ? 1'b0 : 1'b1;
            qdclk = i[0];
            qdata = 4'($urandom);
            qoe   = qncs ? 4'hF : ((i % 4 == 1) ? 4'h0 : 4'($urandom));
            cyc("qspi", 2'b10, 1'b1, 1'b0);
        end

        qncs = 1'b0; qdclk = 1'b1; qoe = 4'hF;
        rst  = 1'b1;
        cyc("rst_own1", 2'b00, 1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc("rst_own1_turn", 2'b00, 1'b1, 1'b0);
        cyc("rst_own1_idle", 2'b00, 1'b0, 1'b0);
        cyc("rst_own1_regnt", 2'b10, 1'b1, 1'b0);
        qncs = 1'b1; req = 2'b00;
        turn("q_turn");

        req = 2'b01;
        cyc("spi_gnt", 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            spi_cs   = 1'b0;
            spi_sck  = i[0];
            spi_mosi = 1'($urandom);
            qncs     = i[1];
            cyc("spi", 2'b01, 1'b1, 1'b0);
        end
        spi_cs = 1'b1; qncs = 1'b1; req = 2'b00;
        turn("spi_turn");

`ifdef FLASH_ARB_TIMEOUT_EN
        spi_cs = 1'b0; req = 2'b01;
        cyc("to_gnt", 2'b01, 1'b1, 1'b0);
        req = 2'b11;
        for (int i = 0; i < 15; i++) cyc("to_hold", 2'b01, 1'b1, 1'b0);
        cyc("to_revoke", 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc("to_turn", 2'b00, 1'b1, 1'b0);
        cyc("to_idle", 2'b00, 1'b0, 1'b0);
        cyc("to_waiter", 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc("to_blocked", 2'b10, 1'b1, 1'b0);
        req = 2'b01;
        turn("to_turn2");
        cyc("to_still_blk", 2'b00, 1'b0, 1'b0);
        req = 2'b00;
        cyc("to_release", 2'b00, 1'b0, 1'b0);
        req = 2'b01;
        cyc("to_regnt", 2'b01, 1'b1, 1'b0);
        req = 2'b00; spi_cs = 1'b1;
        turn("to_end");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
